// File: rtl/approx_add_pkg.sv
// rtl/approx_add_pkg.sv - shared constants and HOERAA golden function for the shared approximate adder
package approx_add_pkg;

  localparam int DEF_N     = 16;
  localparam int DEF_K     = 12;
  localparam int DEF_R     = 4;
  localparam int ERR_CNT_W = 16;

  // Returns {co,sum} right-aligned: sum in [n-1:0], carry out in bit n.
  function automatic logic [32:0] hoeraa_ref(input logic [31:0] a, input logic [31:0] b,
                                             input int n, input int k);
    logic [63:0] aa, bb, mask, up, r;
    logic        c;
    int          l;
    l    = n - k;
    aa   = {32'd0, a};
    bb   = {32'd0, b};
    mask = (64'd1 << k) - 64'd1;
    c    = |((aa >> (l - 1)) & (bb >> (l - 1)) & 64'd1);
    up   = ((aa >> l) & mask) + ((bb >> l) & mask) + {63'd0, c};
    r    = up << l;
    if (c) r = r | ((aa & bb & (64'd1 << (l - 2))) << 1);
    else   r = r | ((aa | bb) & (64'd1 << (l - 1)));
    r = r | ((aa | bb) & (64'd1 << (l - 2)));
    r = r | ((64'd1 << (l - 2)) - 64'd1);
    return r[32:0];
  endfunction

endpackage

// File: rtl/hoeraa.sv
// rtl/hoeraa.sv - HOERAA approximate adder: exact upper K bits, approximated lower N-K bits
module hoeraa #(
  parameter int N = 16,
  parameter int K = 12
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         co
);
  localparam int L = N - K;

  logic c;

  // The top pair of the approximate part predicts the carry into the exact part.
  assign c = a[L-1] & b[L-1];
  assign {co, sum[N-1:L]} = {1'b0, a[N-1:L]} + {1'b0, b[N-1:L]} + {{K{1'b0}}, c};
  assign sum[L-1] = c ? (a[L-2] & b[L-2]) : (a[L-1] | b[L-1]);
  assign sum[L-2] = a[L-2] | b[L-2];

  generate
    if (L > 2) begin : g_low_ones
      assign sum[L-3:0] = '1;
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, search starts one past the last winner
module rr_arbiter #(
  parameter int R   = 4,
  parameter int IDW = $clog2(R)
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [R-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);
  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int o = 1; o <= R; o++) begin
      cand = IDW'((int'(ptr) + o) % R);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt = '0;
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/approx_add_arbiter.sv
// rtl/approx_add_arbiter.sv - one HOERAA adder shared by R requesters with registered, ID-tagged results
module approx_add_arbiter
  import approx_add_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int K   = DEF_K,
  parameter int R   = DEF_R,
  parameter int IDW = $clog2(R)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [R-1:0]         req_valid,
  output logic [R-1:0]         req_ready,
  input  logic [R*N-1:0]       req_a,
  input  logic [R*N-1:0]       req_b,
  input  logic [R-1:0]         req_exact,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [N-1:0]         res_sum,
  output logic                 res_co,
  output logic [IDW-1:0]       res_id,
  output logic                 res_exact,
  output logic                 res_err,
  input  logic                 stat_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  logic                 res_valid_q, res_valid_d;
  logic [N-1:0]         res_sum_q, res_sum_d;
  logic                 res_co_q, res_co_d;
  logic [IDW-1:0]       res_id_q, res_id_d;
  logic                 res_exact_q, res_exact_d;
  logic                 res_err_q, res_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [IDW-1:0]       ptr_q, ptr_d;

  logic           can_load, take;
  logic [R-1:0]   gnt;
  logic [IDW-1:0] gnt_idx;
  logic [N-1:0]   op_a, op_b, ap_sum, ex_sum;
  logic           op_exact, ap_co, ex_co, op_err;

  assign can_load = !res_valid_q || res_ready;

  // Gating with rst_n keeps req_ready low while reset is asserted.
  rr_arbiter #(.R(R), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (can_load && rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign take      = |gnt;

  assign op_a     = req_a[gnt_idx*N +: N];
  assign op_b     = req_b[gnt_idx*N +: N];
  assign op_exact = req_exact[gnt_idx];

  hoeraa #(.N(N), .K(K)) u_hoeraa (
    .a   (op_a),
    .b   (op_b),
    .sum (ap_sum),
    .co  (ap_co)
  );

  assign {ex_co, ex_sum} = {1'b0, op_a} + {1'b0, op_b};
  assign op_err          = {ap_co, ap_sum} != {ex_co, ex_sum};

  always_comb begin
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_co_d    = res_co_q;
    res_id_d    = res_id_q;
    res_exact_d = res_exact_q;
    res_err_d   = res_err_q;
    err_cnt_d   = err_cnt_q;
    ptr_d       = ptr_q;
    if (take) begin
      res_valid_d = 1'b1;
      res_sum_d   = op_exact ? ex_sum : ap_sum;
      res_co_d    = op_exact ? ex_co : ap_co;
      res_id_d    = gnt_idx;
      res_exact_d = op_exact;
      res_err_d   = !op_exact && op_err;
      ptr_d       = gnt_idx;
      if (!op_exact && op_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
    if (stat_clr) err_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_co_q    <= 1'b0;
      res_id_q    <= '0;
      res_exact_q <= 1'b0;
      res_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      ptr_q       <= IDW'(R - 1);
    end else begin
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_co_q    <= res_co_d;
      res_id_q    <= res_id_d;
      res_exact_q <= res_exact_d;
      res_err_q   <= res_err_d;
      err_cnt_q   <= err_cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_co    = res_co_q;
  assign res_id    = res_id_q;
  assign res_exact = res_exact_q;
  assign res_err   = res_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_approx_add_arbiter.sv
// tb/tb_approx_add_arbiter.sv - randomized and directed self-checking bench for approx_add_arbiter
module tb_approx_add_arbiter;
  localparam int TN = 16;
  localparam int TK = 12;
  localparam int TR = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req_valid, req_ready, req_exact;
  logic [63:0]   req_a, req_b;
  logic          res_valid, res_ready, res_co, res_exact, res_err, stat_clr;
  logic [15:0]   res_sum, err_cnt;
  logic [1:0]    res_id;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference state: what the result register and counter should hold.
  logic        m_valid, m_co, m_exact, m_err;
  logic [15:0] m_sum, m_cnt;
  int          m_id, m_ptr;
  logic [3:0]  exp_ready, got_ready;
  logic [15:0] ta [4];
  logic [15:0] tb [4];

  approx_add_arbiter #(.N(TN), .K(TK), .R(TR)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_exact(req_exact),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_co(res_co),
    .res_id(res_id), .res_exact(res_exact), .res_err(res_err),
    .stat_clr(stat_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // {err, co, sum} from the adder rules written as plain integer arithmetic.
  function automatic logic [17:0] ref_model(input int a, input int b, input bit ex);
    int l, c, up, bit1, bit0, full, exact_v;
    l       = TN - TK;
    exact_v = a + b;
    c       = ((a >> (l - 1)) & 1) & ((b >> (l - 1)) & 1);
    up      = (a >> l) + (b >> l) + c;
    bit1    = (c != 0) ? ((a >> (l - 2)) & (b >> (l - 2)) & 1) : (((a | b) >> (l - 1)) & 1);
    bit0    = ((a | b) >> (l - 2)) & 1;
    full    = up * (1 << l) + bit1 * (1 << (l - 1)) + bit0 * (1 << (l - 2)) + (1 << (l - 2)) - 1;
    if (ex) full = exact_v;
    return {(full != exact_v), 17'(full)};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_co = 0; m_exact = 0; m_err = 0; m_sum = 0; m_cnt = 0; m_id = 0; m_ptr = TR - 1;
  endtask

  // Advance one clock from a negedge, predicting grant and result from the current inputs.
  task automatic cycle();
    bit can, clr;
    int win, j;
    logic [17:0] r;
    #1;
    can = !m_valid || res_ready;
    win = -1;
    for (int o = 1; o <= TR; o++) begin
      j = (m_ptr + o) % TR;
      if (win < 0 && ((req_valid >> j) & 4'd1) != 4'd0) win = j;
    end
    exp_ready = (can && win >= 0) ? 4'(1 << win) : 4'd0;
    got_ready = req_ready;
    clr = stat_clr;
    r = '0;
    if (can && win >= 0)
      r = ref_model(int'(req_a[win*16 +: 16]), int'(req_b[win*16 +: 16]), req_exact[win]);
    @(negedge clk);
    if (can && win >= 0) begin
      m_valid = 1; m_sum = r[15:0]; m_co = r[16]; m_err = r[17];
      m_id = win; m_exact = req_exact[win]; m_ptr = win;
      if (r[17] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (res_ready) begin
      m_valid = 0;
    end
    if (clr) m_cnt = 0;
  endtask

  task automatic drive_one(input int id, input logic [15:0] a, input logic [15:0] b, input bit ex);
    req_valid = 4'(1 << id);
    req_a[id*16 +: 16] = a;
    req_b[id*16 +: 16] = b;
    req_exact[id] = ex;
    cycle();
    req_valid = 4'd0;
  endtask

  task automatic test_reset();
    rst_n = 0; req_valid = 4'hF; req_a = '0; req_b = '0; req_exact = 0; res_ready = 1; stat_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 4'd0) begin n_fail++; $display("FAIL rst_ready got %b want 0000", req_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", res_valid); end
    n_cmp++; if ({res_sum, res_co, res_id, res_exact, res_err} !== 21'd0) begin n_fail++;
      $display("FAIL rst_data got %h/%b/%0d/%b/%b want zeros", res_sum, res_co, res_id, res_exact, res_err); end
    n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got %h want 0000", err_cnt); end
    req_valid = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_directed();
    drive_one(0, 16'h000B, 16'h0004, 0);
    n_cmp++; if (got_ready !== 4'b0001) begin n_fail++; $display("FAIL d0_ready got %b want 0001", got_ready); end
    n_cmp++; if (res_valid !== 1'b1 || res_sum !== 16'h000F || res_co !== 1'b0 || res_id !== 2'd0 || res_err !== 1'b0) begin n_fail++;
      $display("FAIL d0_result got v%b %h co%b id%0d err%b want v1 000f co0 id0 err0", res_valid, res_sum, res_co, res_id, res_err); end
    n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL d0_cnt got %h want 0000", err_cnt); end
    drive_one(1, 16'h0008, 16'h0008, 0);
    n_cmp++; if (res_sum !== 16'h0013 || res_co !== 1'b0 || res_id !== 2'd1 || res_err !== 1'b1 || res_exact !== 1'b0) begin n_fail++;
      $display("FAIL d1_approx got %h co%b id%0d err%b ex%b want 0013 co0 id1 err1 ex0", res_sum, res_co, res_id, res_err, res_exact); end
    n_cmp++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL d1_cnt got %h want 0001", err_cnt); end
    drive_one(1, 16'h0008, 16'h0008, 1);
    n_cmp++; if (res_sum !== 16'h0010 || res_err !== 1'b0 || res_exact !== 1'b1) begin n_fail++;
      $display("FAIL d1_exact got %h err%b ex%b want 0010 err0 ex1", res_sum, res_err, res_exact); end
    n_cmp++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL d1_exact_cnt got %h want 0001", err_cnt); end
    drive_one(2, 16'hFFF0, 16'h0010, 0);
    n_cmp++; if (res_sum !== 16'h0003 || res_co !== 1'b1 || res_err !== 1'b1 || res_id !== 2'd2) begin n_fail++;
      $display("FAIL d2_approx got %h co%b err%b id%0d want 0003 co1 err1 id2", res_sum, res_co, res_err, res_id); end
    drive_one(2, 16'hFFF0, 16'h0010, 1);
    n_cmp++; if (res_sum !== 16'h0000 || res_co !== 1'b1 || res_err !== 1'b0) begin n_fail++;
      $display("FAIL d2_exact got %h co%b err%b want 0000 co1 err0", res_sum, res_co, res_err); end
    n_cmp++; if (err_cnt !== m_cnt || m_cnt !== 16'd2) begin n_fail++; $display("FAIL d2_cnt got %h want 0002", err_cnt); end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < TR; i++) begin
      req_a[i*16 +: 16] = 16'($urandom); req_b[i*16 +: 16] = 16'($urandom); req_exact[i] = 1'($urandom);
    end
    req_valid = 4'hF; res_ready = 1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      n_cmp++; if (got_ready !== exp_ready || $countones(got_ready) != 1) begin n_fail++;
        $display("FAIL rr_ready cyc%0d got %b want %b", c, got_ready, exp_ready); end
      n_cmp++; if (res_valid !== 1'b1 || int'(res_id) != m_id || res_sum !== m_sum || res_co !== m_co || res_err !== m_err) begin n_fail++;
        $display("FAIL rr_result cyc%0d got id%0d %h co%b err%b want id%0d %h co%b err%b", c, res_id, res_sum, res_co, res_err, m_id, m_sum, m_co, m_err); end
    end
    req_valid = 0;
    cycle();
    n_cmp++; if (res_valid !== 1'b0 || res_sum !== m_sum) begin n_fail++;
      $display("FAIL rr_drain got v%b %h want v0 %h", res_valid, res_sum, m_sum); end
  endtask

  task automatic test_backpressure();
    logic [15:0] hold_sum;
    drive_one(1, 16'h1234, 16'h0F0F, 0);
    hold_sum = m_sum;
    res_ready = 0; req_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      cycle();
      n_cmp++; if (got_ready !== 4'd0) begin n_fail++; $display("FAIL bp_ready cyc%0d got %b want 0000", c, got_ready); end
      n_cmp++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_sum !== hold_sum || res_err !== m_err) begin n_fail++;
        $display("FAIL bp_hold cyc%0d got v%b id%0d %h want v1 id1 %h", c, res_valid, res_id, res_sum, hold_sum); end
    end
    res_ready = 1;
    cycle();
    req_valid = 0;
    n_cmp++; if (got_ready !== 4'b0100 || res_id !== 2'd2) begin n_fail++;
      $display("FAIL bp_release got ready %b id%0d want 0100 id2", got_ready, res_id); end
  endtask

  task automatic test_random();
    logic [3:0] v;
    v = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < TR; i++) begin
        if (!v[i] || got_ready[i]) begin
          ta[i] = ($urandom_range(0, 3) == 0) ? 16'hFFF8 : 16'($urandom);
          tb[i] = ($urandom_range(0, 3) == 0) ? 16'h0008 : 16'($urandom);
          req_exact[i] = ($urandom_range(0, 3) == 0);
          v[i] = ($urandom_range(0, 1) == 1);
        end else if ($urandom_range(0, 9) == 0) begin
          v[i] = 0;
        end
        req_a[i*16 +: 16] = ta[i];
        req_b[i*16 +: 16] = tb[i];
      end
      req_valid = v;
      res_ready = ($urandom_range(0, 3) != 0);
      stat_clr  = ($urandom_range(0, 63) == 0);
      cycle();
      stat_clr = 0;
      n_cmp++; if (got_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready cyc%0d got %b want %b", c, got_ready, exp_ready); end
      n_cmp++; if (res_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid cyc%0d got %b want %b", c, res_valid, m_valid); end
      n_cmp++; if (res_sum !== m_sum || res_co !== m_co || int'(res_id) != m_id || res_exact !== m_exact || res_err !== m_err) begin n_fail++;
        $display("FAIL rnd_result cyc%0d got %h co%b id%0d ex%b err%b want %h co%b id%0d ex%b err%b",
                 c, res_sum, res_co, res_id, res_exact, res_err, m_sum, m_co, m_id, m_exact, m_err); end
      n_cmp++; if (err_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt cyc%0d got %h want %h", c, err_cnt, m_cnt); end
    end
    req_valid = 0; res_ready = 1;
    cycle();
  endtask

  task automatic test_saturation();
    req_valid = 4'b0001; req_a[15:0] = 16'h0008; req_b[15:0] = 16'h0008; req_exact[0] = 0; res_ready = 1;
    for (int c = 0; c < 65537; c++) cycle();
    n_cmp++; if (err_cnt !== 16'hFFFF || m_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt got %h want ffff", err_cnt); end
    stat_clr = 1;
    cycle();
    stat_clr = 0;
    n_cmp++; if (err_cnt !== 16'd0 || res_err !== 1'b1) begin n_fail++; $display("FAIL clr_cnt got %h err%b want 0000 err1", err_cnt, res_err); end
    cycle();
    n_cmp++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL clr_next got %h want 0001", err_cnt); end
  endtask

  task automatic test_async_reset();
    req_valid = 4'hF;
    cycle();
    #2 rst_n = 0;
    #1;
    n_cmp++; if (res_valid !== 1'b0 || err_cnt !== 16'd0 || res_sum !== 16'd0) begin n_fail++;
      $display("FAIL arst_state got v%b cnt %h sum %h want v0 0000 0000", res_valid, err_cnt, res_sum); end
    n_cmp++; if (req_ready !== 4'd0) begin n_fail++; $display("FAIL arst_ready got %b want 0000", req_ready); end
    @(negedge clk);
    rst_n = 1;
    model_reset();
    cycle();
    req_valid = 0;
    n_cmp++; if (got_ready !== 4'b0001 || res_id !== 2'd0 || res_valid !== 1'b1) begin n_fail++;
      $display("FAIL arst_prio got ready %b id%0d v%b want 0001 id0 v1", got_ready, res_id, res_valid); end
  endtask

  initial begin
    got_ready = 0; exp_ready = 0;
    test_reset();
    test_directed();
    test_round_robin();
    test_backpressure();
    test_random();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
